// File: rtl/ucsbece152a_pkg.sv
// Shared types and constants for the board input conditioning blocks.
package ucsbece152a_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/ucsbece152a_sync.sv
// Flop-chain synchronizer for an asynchronous single-bit input; resets to 0.
module ucsbece152a_sync #(
    parameter int unsigned STAGES = 2  // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/ucsbece152a_button_conditioner.sv
// Synchronizes and debounces one push-button; emits a clean level, press/release
// pulses and a step pulse with optional auto-repeat while held.
module ucsbece152a_button_conditioner
    import ucsbece152a_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned ACTIVE_LOW_IN   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic step_o
);

    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PER_LAST   = REP_W'(REPEAT_PERIOD - 1);
    localparam logic [REP_W-1:0] REP_TOP    = REP_W'(REP_MAX - 1);
    localparam logic             INVERT     = (ACTIVE_LOW_IN != 0);

    logic btn_n, btn_s;

    assign btn_n = btn_i ^ INVERT;

    ucsbece152a_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_n),
        .q   (btn_s)
    );

    btn_state_t       state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    // 0 = waiting for the initial delay, 1 = running at the repeat period
    logic             rep_phase_q, rep_phase_d;
    logic             level_d, press_d, release_d, step_d, tick;

    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        tick        = 1'b0;

        unique case (state_q)
            RELEASED: begin
                if (btn_s) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = RELEASED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    rep_cnt_d   = '0;
                    rep_phase_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end else if (REPEAT_EN != 0) begin
                    if (rep_cnt_q == (rep_phase_q ? PER_LAST : DELAY_LAST)) begin
                        tick        = 1'b1;
                        rep_cnt_d   = '0;
                        rep_phase_d = 1'b1;
                    end else if (rep_cnt_q != REP_TOP) begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d     = HELD;
                    rep_cnt_d   = '0;
                    rep_phase_d = 1'b0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase

        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
        step_d  = press_d | tick;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RELEASED;
            deb_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
            level_o     <= 1'b0;
            press_o     <= 1'b0;
            release_o   <= 1'b0;
            step_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            level_o     <= level_d;
            press_o     <= press_d;
            release_o   <= release_d;
            step_o      <= step_d;
        end
    end

endmodule

// File: tb/tb_ucsbece152a_button_conditioner.sv
// Directed bench: debounce latency, bounce rejection, auto-repeat, release, reset.
module tb_ucsbece152a_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic level, press, rel, step;
    logic level_nr, press_nr, rel_nr, step_nr;

    int passed = 0;
    int total  = 0;
    int nr_steps;

    always #5 clk = ~clk;

    ucsbece152a_button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .ACTIVE_LOW_IN   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn),
        .level_o   (level),
        .press_o   (press),
        .release_o (rel),
        .step_o    (step)
    );

    ucsbece152a_button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (0),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .ACTIVE_LOW_IN   (1)
    ) dut_nr (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn),
        .level_o   (level_nr),
        .press_o   (press_nr),
        .release_o (rel_nr),
        .step_o    (step_nr)
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, k, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with the button already held down
        rst = 1'b0;
        btn = 1'b0;
        #2;
        chk("rst_level", -1, level, 0);
        chk("rst_press", -1, press, 0);
        chk("rst_release", -1, rel, 0);
        chk("rst_step", -1, step, 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_level_hold", -1, level, 0);
        chk("rst_step_hold", -1, step, 0);
        next_cycle();

        // Release reset, keep pressed for 30 cycles: press at 7, repeats at 17,20,...
        rst = 1'b1;
        nr_steps = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("s1_press", k, press, (k == 7));
            chk("s1_step", k, step,
                (k == 7 || k == 17 || k == 20 || k == 23 || k == 26 || k == 29));
            chk("s1_level", k, level, (k >= 7));
            chk("s1_release", k, rel, 0);
            chk("s1_nr_level", k, level_nr, (k >= 7));
            chk("s1_nr_press", k, press_nr, (k == 7));
            if (step_nr) nr_steps++;
            next_cycle();
        end
        chk("norepeat_step_count", 30, nr_steps, 1);

        // Let go at cycle 30: release pulse at 37
        btn = 1'b1;
        for (int k = 30; k < 46; k++) begin
            @(negedge clk);
            chk("s4_release", k, rel, (k == 37));
            chk("s4_level", k, level, (k < 37));
            chk("s4_press", k, press, 0);
            if (k >= 33) chk("s4_step", k, step, 0);
            chk("s4_nr_step", k, step_nr, 0);
            chk("s4_nr_release", k, rel_nr, (k == 37));
            next_cycle();
        end

        // Bounce: 3 cycles pressed, 3 released, five times
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 6; c++) begin
                btn = (c < 3) ? 1'b0 : 1'b1;
                @(negedge clk);
                chk("s2_press", r * 6 + c, press, 0);
                chk("s2_step", r * 6 + c, step, 0);
                chk("s2_level", r * 6 + c, level, 0);
                next_cycle();
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s2_tail_level", k, level, 0);
            chk("s2_tail_press", k, press, 0);
            next_cycle();
        end

        // Release bounce: press, 2-cycle release at 12..13, re-enter HELD at 17
        for (int k = 0; k < 36; k++) begin
            btn = (k == 12 || k == 13) ? 1'b1 : 1'b0;
            @(negedge clk);
            chk("s5_press", k, press, (k == 7));
            chk("s5_step", k, step, (k == 7 || k == 27 || k == 30 || k == 33));
            chk("s5_level", k, level, (k >= 7));
            chk("s5_release", k, rel, 0);
            chk("s5_nr_step", k, step_nr, (k == 7));
            next_cycle();
        end

        // Reset mid-hold (a repeat step is due this cycle): outputs drop immediately
        rst = 1'b0;
        #1;
        chk("s6_async_level", 36, level, 0);
        chk("s6_async_step", 36, step, 0);
        chk("s6_async_release", 36, rel, 0);
        @(negedge clk);
        chk("s6_rst_level", 36, level, 0);
        chk("s6_rst_release", 36, rel, 0);
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            chk("s6_press", k, press, (k == 7));
            chk("s6_step", k, step, (k == 7));
            chk("s6_level", k, level, (k >= 7));
            chk("s6_release", k, rel, 0);
            next_cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
